relay_sequencer: RTL
====================

Name: relay_sequencer

Overview:
- Finite-state sequencer (FSA) of the relay computer. It generates the one-hot phase vector that the instruction decoder consumes to assert register load/select, memory and ALU controls.
- Each instruction runs as a fixed 8-state fetch followed by an execute tail. The total instruction length (8..24 states) is supplied by the decoder at the end of fetch.
- Also owns run/halt state for the whole machine.

Parameters:
- MAX_STATES, 24, states in the longest instruction (GOTO); sets fsm_out width.
- FETCH_STATES, 8, fetch states common to every instruction.
- IDX_W, 5, width of state index; must satisfy 2**IDX_W >= MAX_STATES.

Ports:
- clock  input  1  system clock; all state advances on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clock.
- run  input  1  level; machine runs while high and not halted.
- resume  input  1  one-cycle pulse; leaves HALTED.
- inst_len  input  IDX_W  total states for the current instruction; sampled at state FETCH_STATES-1.
- halt_req  input  1  from decoder; HALT instruction in execute.
- fsm_out  output  MAX_STATES  one-hot phase; bit k high during state k.
- state_idx  output  IDX_W  binary index of the current state.
- fetch_phase  output  1  high while state_idx < FETCH_STATES.
- inst_done  output  1  one-cycle pulse in the last state of each instruction.
- halted  output  1  high in HALTED.
- len_err  output  1  sticky; illegal inst_len was seen.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (reset==0 at clock edge), regardless of current state or mid-instruction:
  - Go to IDLE.
  - fsm_out=0, state_idx=0, fetch_phase=0, inst_done=0, halted=0, len_err=0, latched length=MAX_STATES.
- IDLE: fsm_out=0. When run==1 at an edge, go to RUN with state_idx=0, so fsm_out[0]=1 on the next cycle.
- RUN: state_idx increments by 1 per cycle.
  - fsm_out is registered and always equals one-hot(state_idx); exactly one bit is high.
  - At state_idx==FETCH_STATES-1, latch inst_len; the latched value takes effect at the next edge.
  - Legal lengths are FETCH_STATES..MAX_STATES and even. Any other value: latch MAX_STATES and set len_err (sticky until reset).
  - inst_done=1 while state_idx==latched_len-1.
  - On the edge after the last state, state_idx wraps to 0. There are no gap cycles.
- run deasserted in RUN: the current instruction completes. After the last state, go to IDLE; never stop mid-instruction.
- halt_req sampled high at any execute state (state_idx>=FETCH_STATES): the instruction completes, then go to HALTED. halt_req during fetch is ignored.
- HALTED: fsm_out=0, state_idx=0, halted=1.
  - resume pulse with run==1: go to RUN at state 0.
  - resume with run==0: go to IDLE.
- Simultaneous events in the last state:
  - halt_req and run==0 together: HALTED wins.
  - resume while not HALTED: ignored.
- inst_done is never asserted outside RUN.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input step_mode (1) and input step (1, one-cycle pulse).
  - While step_mode==1 in RUN, state_idx advances only on cycles with step==1; fsm_out holds otherwise.
  - inst_done stays high while held in the last state. halt, wrap and length rules are unchanged.
  - step_mode changes take effect at the next edge.
- Undefined: neither port exists, and RUN advances every cycle.

Decomposition:
- Package relay_seq_pkg holds:
  - constants MAX_STATES, FETCH_STATES;
  - seq_state_t enum {IDLE, RUN, HALTED};
  - length codes LEN_8, LEN_10, LEN_12, LEN_14, LEN_24 shared with the decoder.
- One sub-module, seq_phase_decode: registered binary-to-one-hot of state_idx plus the fetch_phase flag. All control stays in relay_sequencer.

Test Plan:
- Reset, then run=1, inst_len=8 → fsm_out bit 0..7 over 8 cycles, inst_done at idx 7, wrap to bit 0 with no gap; one-hot checked every cycle.
- inst_len=24 sampled at idx 7 → 24-state instruction; inst_done only at idx 23; fetch_phase high for idx 0..7 only.
- inst_len=13, then inst_len=30 → each runs 24 states; len_err=1 and stays 1 through a later legal length; cleared by reset=0.
- halt_req pulsed at idx 9 of a 12-state instruction → completes to idx 11, then halted=1, fsm_out=0. resume with run=1 → restarts at idx 0. halt_req at idx 3 → ignored.
- run=0 at idx 5 → finishes idx 7 (len 8) → IDLE. reset=0 at idx 15 of a 24-state instruction → IDLE and all outputs 0 on the next cycle.
- With SEQ_SINGLE_STEP_EN: step_mode=1, three step pulses spaced 5 cycles apart → idx advances 0→1→2→3 only on step cycles; fsm_out stable between pulses.

Source files
------------

// File: rtl/relay_seq_pkg.sv
// Shared constants, state type and instruction length codes for the relay sequencer.
// Optional single-step support is selected by SEQ_SINGLE_STEP_EN in relay_sequencer.sv.
package relay_seq_pkg;

  localparam int unsigned MAX_STATES   = 24;
  localparam int unsigned FETCH_STATES = 8;
  localparam int unsigned IDX_W        = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } seq_state_t;

  // Instruction lengths the decoder drives onto inst_len
  localparam logic [IDX_W-1:0] LEN_8  = IDX_W'(8);
  localparam logic [IDX_W-1:0] LEN_10 = IDX_W'(10);
  localparam logic [IDX_W-1:0] LEN_12 = IDX_W'(12);
  localparam logic [IDX_W-1:0] LEN_14 = IDX_W'(14);
  localparam logic [IDX_W-1:0] LEN_24 = IDX_W'(24);

endpackage

// File: rtl/seq_phase_decode.sv
// Registered binary-to-one-hot phase decode plus fetch flag; both read zero outside RUN.
module seq_phase_decode #(
  parameter int unsigned MaxStates   = 24,
  parameter int unsigned FetchStates = 8,
  parameter int unsigned IdxW        = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  input  logic [IdxW-1:0]      idx_i,
  output logic [MaxStates-1:0] fsm_out_o,
  output logic                 fetch_phase_o
);

  logic [MaxStates-1:0] onehot_d, onehot_q;
  logic                 fetch_d, fetch_q;

  always_comb begin
    onehot_d = '0;
    for (int k = 0; k < MaxStates; k++) begin
      onehot_d[k] = run_i && (idx_i == IdxW'(k));
    end
    fetch_d = run_i && (idx_i < IdxW'(FetchStates));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      onehot_q <= '0;
      fetch_q  <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      fetch_q  <= fetch_d;
    end
  end

  assign fsm_out_o     = onehot_q;
  assign fetch_phase_o = fetch_q;

endmodule

// File: rtl/relay_sequencer.sv
// Relay computer phase sequencer: fetch + variable execute tail, run/halt control.
// Define SEQ_SINGLE_STEP_EN to add step_mode/step inputs for manual phase stepping.
module relay_sequencer #(
  parameter int unsigned MaxStates   = relay_seq_pkg::MAX_STATES,
  parameter int unsigned FetchStates = relay_seq_pkg::FETCH_STATES,
  parameter int unsigned IdxW        = relay_seq_pkg::IDX_W
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step_mode,
  input  logic                 step,
`endif
  input  logic                 run,
  input  logic                 resume,
  input  logic [IdxW-1:0]      inst_len,
  input  logic                 halt_req,
  output logic [MaxStates-1:0] fsm_out,
  output logic [IdxW-1:0]      state_idx,
  output logic                 fetch_phase,
  output logic                 inst_done,
  output logic                 halted,
  output logic                 len_err
);
  import relay_seq_pkg::*;

  localparam logic [IdxW-1:0] FetchLen  = IdxW'(FetchStates);
  localparam logic [IdxW-1:0] FetchLast = IdxW'(FetchStates - 1);
  localparam logic [IdxW-1:0] MaxLen    = IdxW'(MaxStates);

  seq_state_t      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] len_q, len_d;
  logic            len_err_q, len_err_d;
  logic            halt_pend_q, halt_pend_d;

  logic            in_run, advance, len_ok, at_latch, last, exec_halt, halt_now;
  logic [IdxW-1:0] eff_len;

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = !step_mode || step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    in_run    = (state_q == RUN);
    len_ok    = (inst_len >= FetchLen) && (inst_len <= MaxLen) && !inst_len[0];
    at_latch  = in_run && (idx_q == FetchLast);
    // The length sampled at the end of fetch already governs that same state's done check
    eff_len   = at_latch ? (len_ok ? inst_len : MaxLen) : len_q;
    last      = in_run && (idx_q == eff_len - IdxW'(1));
    exec_halt = in_run && halt_req && (idx_q >= FetchLen);
    halt_now  = halt_pend_q || exec_halt;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    len_err_d   = len_err_q;
    halt_pend_d = halt_pend_q || exec_halt;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (advance) begin
          if (at_latch) begin
            len_d = eff_len;
            if (!len_ok) len_err_d = 1'b1;
          end
          if (last) begin
            idx_d       = '0;
            halt_pend_d = 1'b0;
            if (halt_now) begin
              state_d = HALTED;
            end else if (!run) begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      HALTED: begin
        idx_d = '0;
        if (resume) state_d = run ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= MaxLen;
      len_err_q   <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      len_err_q   <= len_err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  seq_phase_decode #(
    .MaxStates  (MaxStates),
    .FetchStates(FetchStates),
    .IdxW       (IdxW)
  ) u_phase_decode (
    .clk_i        (clock),
    .rst_ni       (reset),
    .run_i        (state_d == RUN),
    .idx_i        (idx_d),
    .fsm_out_o    (fsm_out),
    .fetch_phase_o(fetch_phase)
  );

  assign state_idx = idx_q;
  assign inst_done = last;
  assign halted    = (state_q == HALTED);
  assign len_err   = len_err_q;

endmodule
